// File: rtl/vec_mem_sequencer.sv
// Vector load/store sequencer: breaks a LANES-element vector access into one word
// access per granted cycle on the shared single-port data memory. Scalar requests
// win arbitration, but only MAX_STALL times in a row while a vector element waits.
module vec_mem_sequencer #(
  parameter int unsigned LANES     = 4,
  parameter int unsigned DW        = 32,
  parameter int unsigned AW        = 32,
  parameter int unsigned MAX_STALL = 4
) (
  input  logic                clk,
  input  logic                reset,
  // scalar core side
  input  logic                s_req,
  input  logic                s_we,
  input  logic [AW-1:0]       s_addr,
  input  logic [DW-1:0]       s_wdata,
  output logic                s_gnt,
  output logic [DW-1:0]       s_rdata,
  // vector load/store unit side
  input  logic                v_start,
  input  logic                v_we,
  input  logic [AW-1:0]       v_base,
  input  logic [AW-1:0]       v_stride,
  input  logic [LANES*DW-1:0] v_wdata,
  output logic                v_busy,
  output logic                v_done,
  output logic [LANES*DW-1:0] v_rdata,
  // data memory port
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  input  logic [DW-1:0]       mem_rdata
);

  localparam int unsigned IW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned SW = $clog2(MAX_STALL + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] stride_q;
  logic [DW-1:0] wdata_q [LANES];
  logic [DW-1:0] rdata_q [LANES];
  logic [IW-1:0] idx_q;
  logic [SW-1:0] stall_q;
  logic          cap_q;
  logic [IW-1:0] cap_idx_q;

  logic          start;
  logic          vec_issue;
  logic          last_lane;

  // Arbitration: the vector element takes the port unless a scalar request is
  // present and the scalar side has not yet used up its consecutive-grant budget.
  always_comb begin
    start     = (state_q == StIdle) && v_start;
    vec_issue = (state_q == StIssue) && !(s_req && (stall_q < SW'(MAX_STALL)));
    last_lane = (idx_q == IW'(LANES - 1));
    s_gnt     = s_req && !vec_issue;
  end

  // Memory port mux; idle port drives zeros.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (vec_issue) begin
      mem_we    = we_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q[idx_q];
    end else if (s_gnt) begin
      mem_we    = s_we;
      mem_addr  = s_addr;
      mem_wdata = s_wdata;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (v_start) state_d = StIssue;
      StIssue: if (vec_issue && last_lane) state_d = we_q ? StDone : StDrain;
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Control state: FSM, element index, stall counter and pending read capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      stall_q   <= '0;
      cap_q     <= 1'b0;
      cap_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      cap_q     <= vec_issue && !we_q;
      cap_idx_q <= idx_q;
      if (start) begin
        idx_q <= '0;
      end else if (vec_issue) begin
        idx_q   <= last_lane ? '0 : idx_q + IW'(1);
        stall_q <= '0;
      end else if (state_q == StIssue) begin
        // Only reachable with a granted scalar request inside the budget.
        stall_q <= stall_q + SW'(1);
      end
    end
  end

  // Operand latch and address walk; values are only consumed while busy, so
  // they need no reset.
  always_ff @(posedge clk) begin
    if (start) begin
      we_q     <= v_we;
      addr_q   <= v_base;
      stride_q <= v_stride;
      for (int i = 0; i < int'(LANES); i++) begin
        wdata_q[i] <= v_wdata[i*DW +: DW];
      end
    end else if (vec_issue) begin
      addr_q <= addr_q + stride_q;
    end
  end

  // Load result lanes: memory data arrives one cycle after the read issue.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(LANES); i++) begin
        rdata_q[i] <= '0;
      end
    end else if (cap_q) begin
      rdata_q[cap_idx_q] <= mem_rdata;
    end
  end

  // Status and packed read data.
  always_comb begin
    v_busy  = (state_q == StIssue) || (state_q == StDrain);
    v_done  = (state_q == StDone);
    s_rdata = mem_rdata;
    v_rdata = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      v_rdata[i*DW +: DW] = rdata_q[i];
    end
  end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Bench for vec_mem_sequencer: reset checks, a table of idle scalar accesses,
// directed vector operations, a mid-operation reset, and randomized operations
// with random scalar traffic checked against a schedule-level reference model.
module tb_vec_mem_sequencer;

  localparam int unsigned LANES     = 4;
  localparam int unsigned DW        = 32;
  localparam int unsigned AW        = 32;
  localparam int unsigned MAX_STALL = 4;
  localparam int          MAXC      = 40;

  logic                clk = 1'b0;
  logic                reset;
  logic                s_req, s_we;
  logic [AW-1:0]       s_addr;
  logic [DW-1:0]       s_wdata;
  logic                s_gnt;
  logic [DW-1:0]       s_rdata;
  logic                v_start, v_we;
  logic [AW-1:0]       v_base, v_stride;
  logic [LANES*DW-1:0] v_wdata;
  logic                v_busy, v_done;
  logic [LANES*DW-1:0] v_rdata;
  logic                mem_we;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_wdata;
  logic [DW-1:0]       mem_rdata = '0;

  vec_mem_sequencer #(
    .LANES(LANES), .DW(DW), .AW(AW), .MAX_STALL(MAX_STALL)
  ) dut (
    .clk(clk), .reset(reset),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rdata(s_rdata),
    .v_start(v_start), .v_we(v_we), .v_base(v_base), .v_stride(v_stride),
    .v_wdata(v_wdata), .v_busy(v_busy), .v_done(v_done), .v_rdata(v_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory attached to the DUT, word-indexed by address bits [11:2].
  bit [31:0] mem [1024];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[11:2]];
  end

  // Reference state: expected memory contents and expected v_rdata lanes.
  bit [31:0]     ref_mem [1024];
  logic [DW-1:0] m_rdata [LANES];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LANES*DW-1:0] pack(input logic [DW-1:0] l [LANES]);
    logic [LANES*DW-1:0] r;
    for (int i = 0; i < int'(LANES); i++) r[i*DW +: DW] = l[i];
    return r;
  endfunction

  // One vector operation starting in IDLE. mode 0: no scalar traffic, 1: scalar
  // request every cycle, 2: random scalar traffic and ignored v_start re-pulses.
  // The model first derives the whole grant schedule, then checks every cycle.
  task automatic run_op(input string tag, input logic we, input logic [31:0] base,
                        input logic [31:0] stride, input logic [DW-1:0] wd [LANES],
                        input int mode);
    logic          reqs [MAXC];
    logic          swe  [MAXC];
    logic [31:0]   sad  [MAXC];
    logic [31:0]   swd  [MAXC];
    int            issue_k [MAXC];
    logic [DW-1:0] exp_rd [LANES];
    int            k, consec, c, done_c;
    for (int i = 0; i < MAXC; i++) begin
      reqs[i]    = (mode == 1) ? 1'b1 : (mode == 2) ? ($urandom_range(0, 99) < 60) : 1'b0;
      swe[i]     = 1'($urandom_range(0, 1));
      sad[i]     = 32'h200 + 32'(4 * $urandom_range(0, 31));
      swd[i]     = $urandom;
      issue_k[i] = -1;
    end
    k = 0;
    consec = 0;
    c = 1;
    while (k < int'(LANES)) begin
      if (reqs[c] && consec < int'(MAX_STALL)) begin
        consec++;
      end else begin
        issue_k[c] = k;
        k++;
        consec = 0;
      end
      c++;
    end
    done_c = (c - 1) + (we ? 1 : 2);
    for (int i = 0; i < int'(LANES); i++) exp_rd[i] = m_rdata[i];

    for (int cy = 0; cy <= done_c + 1; cy++) begin
      logic          egnt, ewe, ebusy, edone;
      logic [31:0]   ea, ewd;
      if (cy == 0) begin
        v_start  = 1'b1;
        v_we     = we;
        v_base   = base;
        v_stride = stride;
        v_wdata  = pack(wd);
      end else begin
        v_start  = (mode == 2) && (cy <= done_c) && ($urandom_range(0, 3) == 0);
        v_we     = 1'($urandom_range(0, 1));
        v_base   = $urandom;
        v_stride = $urandom;
        v_wdata  = {$urandom, $urandom, $urandom, $urandom};
      end
      s_req   = reqs[cy];
      s_we    = swe[cy];
      s_addr  = sad[cy];
      s_wdata = swd[cy];
      egnt = 1'b0;
      ewe  = 1'b0;
      ea   = '0;
      ewd  = '0;
      if (issue_k[cy] >= 0) begin
        ea  = base + stride * 32'(issue_k[cy]);
        ewe = we;
        ewd = wd[issue_k[cy]];
        if (we) ref_mem[ea[11:2]] = ewd;
        else    exp_rd[issue_k[cy]] = ref_mem[ea[11:2]];
      end else if (reqs[cy]) begin
        egnt = 1'b1;
        ewe  = swe[cy];
        ea   = sad[cy];
        ewd  = swd[cy];
        if (ewe) ref_mem[ea[11:2]] = ewd;
      end
      ebusy = (cy >= 1) && (cy < done_c);
      edone = (cy == done_c);
      @(negedge clk);
      check($sformatf("%s cyc%0d port", tag, cy),
            {s_gnt, v_busy, v_done, mem_we, mem_addr, mem_wdata, s_rdata},
            {egnt, ebusy, edone, ewe, ea, ewd, mem_rdata});
      if (cy >= done_c) check($sformatf("%s cyc%0d v_rdata", tag, cy), v_rdata, pack(exp_rd));
      next_cycle();
    end
    for (int i = 0; i < int'(LANES); i++) m_rdata[i] = exp_rd[i];
    v_start = 1'b0;
    s_req   = 1'b0;
  endtask

  typedef struct {
    logic        s_req;
    logic        s_we;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic        e_gnt;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        chk_rd;
    logic [31:0] e_rd;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    vec_t          tbl [4];
    logic [DW-1:0] wd [LANES];
    int            wr;
    logic          done_seen;

    tbl[0] = '{1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 32'h40, 32'h12345678, 1'b1, 1'b0, 32'h40, 32'h12345678, 1'b0, 32'h0};
    tbl[2] = '{1'b0, 1'b1, 32'h48, 32'h0000CAFE, 1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 32'hDEADBEEF};
    tbl[3] = '{1'b0, 1'b0, 32'h4C, 32'h5555AAAA, 1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 32'h0};

    reset    = 1'b0;
    s_req    = 1'b0;
    s_we     = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    v_start  = 1'b0;
    v_we     = 1'b0;
    v_base   = '0;
    v_stride = '0;
    v_wdata  = '0;
    for (int i = 0; i < int'(LANES); i++) m_rdata[i] = '0;

    // Reset state
    repeat (3) next_cycle();
    @(negedge clk);
    check("reset status", {v_busy, v_done, s_gnt, mem_we, mem_addr, mem_wdata}, '0);
    check("reset v_rdata", v_rdata, '0);
    next_cycle();
    reset = 1'b1;

    // Scalar accesses while idle
    for (int i = 0; i < 4; i++) begin
      s_req   = tbl[i].s_req;
      s_we    = tbl[i].s_we;
      s_addr  = tbl[i].s_addr;
      s_wdata = tbl[i].s_wdata;
      if (tbl[i].e_we) ref_mem[tbl[i].e_addr[11:2]] = tbl[i].e_wdata;
      @(negedge clk);
      check($sformatf("tbl%0d port", i), {s_gnt, mem_we, mem_addr, mem_wdata},
            {tbl[i].e_gnt, tbl[i].e_we, tbl[i].e_addr, tbl[i].e_wdata});
      if (tbl[i].chk_rd) check($sformatf("tbl%0d s_rdata", i), s_rdata, tbl[i].e_rd);
      next_cycle();
    end
    s_req = 1'b0;

    // Uncontended store then load of the same region
    wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
    run_op("store", 1'b1, 32'h100, 32'h4, wd, 0);
    for (int i = 0; i < int'(LANES); i++) wd[i] = $urandom;
    run_op("load", 1'b0, 32'h100, 32'h4, wd, 0);

    // Scalar requests held throughout a store
    for (int i = 0; i < int'(LANES); i++) wd[i] = $urandom;
    run_op("starve", 1'b1, 32'h180, 32'h4, wd, 1);

    // Negative stride wrapping below zero, then read back
    for (int i = 0; i < int'(LANES); i++) wd[i] = $urandom;
    run_op("negstr", 1'b1, 32'h0, 32'hFFFFFFFC, wd, 0);
    run_op("negld", 1'b0, 32'h0, 32'hFFFFFFFC, wd, 0);

    // Re-pulsed v_start ignored, reset after two element issues
    wr = 0;
    done_seen = 1'b0;
    v_start  = 1'b1;
    v_we     = 1'b1;
    v_base   = 32'h300;
    v_stride = 32'h4;
    v_wdata  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    next_cycle();
    v_base = 32'h500;
    @(negedge clk);
    check("abort issue0", {mem_we, mem_addr, mem_wdata}, {1'b1, 32'h300, 32'hA0});
    if (mem_we) wr++;
    next_cycle();
    v_start = 1'b0;
    reset   = 1'b0;
    @(negedge clk);
    check("abort issue1", {mem_we, mem_addr, mem_wdata}, {1'b1, 32'h304, 32'hA1});
    if (mem_we) wr++;
    ref_mem[32'h300 >> 2] = 32'hA0;
    ref_mem[32'h304 >> 2] = 32'hA1;
    for (int i = 0; i < int'(LANES); i++) m_rdata[i] = '0;
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    check("abort idle", {v_busy, v_done, mem_we}, 3'b000);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_we) wr++;
      if (v_done) done_seen = 1'b1;
      next_cycle();
    end
    check("abort writes", 32'(wr), 32'd2);
    check("abort no done", done_seen, 1'b0);
    check("abort v_rdata", v_rdata, '0);
    for (int i = 0; i < int'(LANES); i++) wd[i] = 32'hB0 + 32'(i);
    run_op("after", 1'b1, 32'h300, 32'h4, wd, 0);
    run_op("afterld", 1'b0, 32'h300, 32'h4, wd, 0);

    // Randomized operations with random scalar traffic
    for (int n = 0; n < 30; n++) begin
      logic [31:0] stride;
      case ($urandom_range(0, 4))
        0:       stride = 32'h0;
        1:       stride = 32'h4;
        2:       stride = 32'hFFFFFFFC;
        3:       stride = 32'h8;
        default: stride = 32'hFFFFFFF8;
      endcase
      for (int i = 0; i < int'(LANES); i++) wd[i] = $urandom;
      run_op($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)),
             32'h200 + 32'(4 * $urandom_range(0, 15)), stride, wd, 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vec_mem_sequencer.md
Name: vec_mem_sequencer

Overview:
Sequences vector load/store operations onto the single-port data memory as per-element word accesses, one element per granted cycle. Shares that port with the scalar core's memory interface (write enable, address, write data). Scalar accesses have priority, bounded by a starvation guard that guarantees vector progress. Sits between the scalar core, the vector load/store unit and the data memory inside the top-level processor.

Parameters:
LANES, 4, vector elements per operation (≥1)
DW, 32, element/data width in bits
AW, 32, address width in bits
MAX_STALL, 4, maximum consecutive scalar grants while a vector element is pending (≥1)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-low reset (reset=0 resets)
s_req  in  1  scalar memory access request
s_we  in  1  scalar write enable
s_addr  in  AW  scalar address
s_wdata  in  DW  scalar write data
s_gnt  out  1  scalar granted the memory port this cycle (combinational)
s_rdata  out  DW  passthrough of mem_rdata
v_start  in  1  start pulse for a vector operation
v_we  in  1  1=store, 0=load
v_base  in  AW  byte address of lane 0
v_stride  in  AW  byte stride between lanes (two's complement)
v_wdata  in  LANES*DW  store data; lane i = bits [DW*i+DW-1 : DW*i]
v_busy  out  1  operation in progress
v_done  out  1  one-cycle completion pulse
v_rdata  out  LANES*DW  load result, same lane packing
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid the cycle after a read address is presented

Behaviour:
- States: IDLE, ISSUE, DRAIN, DONE.
- Reset (any state, including mid-operation): state=IDLE, v_busy=0, v_done=0, v_rdata=0, stall count=0, element index=0, no pending read capture. Writes already issued are not undone.
- IDLE: v_start=1 latches v_we, v_base, v_stride and v_wdata, sets the element index to 0 and the current address to v_base, then moves to ISSUE. v_busy=1 from the next cycle.
- v_start is ignored in every state other than IDLE.
- ISSUE, each cycle:
  - If s_req=1 and stall count < MAX_STALL: the scalar access is granted and the stall count increments.
  - Otherwise the vector element is issued: mem_we=latched we, mem_addr=current address, mem_wdata=latched lane[index]. The stall count clears, current address += stride (mod 2^AW, wrap-around allowed), and the index increments.
  - After the lane LANES-1 issue: store goes to DONE; load goes to DRAIN.
- Load capture: a vector read issued in cycle t writes mem_rdata into v_rdata lane[index] at the end of cycle t+1. Capture occurs in any state.
- DRAIN: captures the last lane, then goes to DONE (exactly one cycle).
- DONE: v_done=1 and v_busy=0 for one cycle, then IDLE.
- v_rdata holds its value until overwritten lane-by-lane by the next load. Stores never modify it.
- In IDLE, DRAIN and DONE, a scalar request is granted immediately and the stall count does not change.
- With no grant, mem_we=0, mem_addr=0 and mem_wdata=0. When the scalar is granted, mem_* follow s_*. s_gnt=0 whenever the vector side owns the port.
- Stride 0 is legal: every lane accesses the same address.
- Uncontended latency, with v_start in cycle 0: issues occur in cycles 1..LANES. A store has v_done in cycle LANES+1; a load has v_done in cycle LANES+2.

Test Plan:
1. Store, LANES=4, base 0x100, stride 4, lanes 0x11/0x22/0x33/0x44, no scalar traffic -> mem_we=1 at 0x100/0x104/0x108/0x10C with that data in cycles 1-4; v_done in cycle 5; v_busy high in cycles 1-4.
2. Load of the same region -> v_rdata lanes 0..3 = 0x11, 0x22, 0x33, 0x44; v_done in cycle 6; v_rdata stable afterwards.
3. s_req held at 1 throughout a 4-lane store, MAX_STALL=4 -> repeating pattern of 4 scalar grants then 1 vector issue; all 4 elements written; v_done in cycle 21.
4. Base 0x0, stride 0xFFFFFFFC -> addresses 0x0, 0xFFFFFFFC, 0xFFFFFFF8, 0xFFFFFFF4.
5. v_start re-pulsed during ISSUE -> ignored. reset=0 after 2 elements are issued -> next cycle IDLE with v_busy=0 and v_done never pulsing; exactly 2 writes observed; a following v_start operates normally.
6. Scalar s_req=1, s_we=1, addr 0x40, data 0xDEADBEEF in IDLE -> s_gnt=1 in the same cycle; mem_we=1, mem_addr=0x40, mem_wdata=0xDEADBEEF.
